// File: rtl/param_pushdown_stack_pkg.sv
// Shared definitions for the pushdown stack: default geometry, operation
// encoding and the operation decode helper.
package param_pushdown_stack_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_REPL = 2'd3;

  // push&pop on an empty stack degrades to a plain push
  function automatic logic [1:0] decode_op(input logic push, input logic pop,
                                           input logic empty);
    logic [1:0] op;
    if (push && pop && !empty) begin
      op = OP_REPL;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end else begin
      op = OP_IDLE;
    end
    return op;
  endfunction

endpackage

// File: rtl/param_pushdown_stack_onehot_decoder.sv
// Parametrised N-to-2**N one-hot decoder with enable; drives the per-entry
// write enables of the stack storage.
module onehot_decoder #(
  parameter int N = 3
) (
  output logic [2**N-1:0] O,
  input  logic [N-1:0]    I,
  input  logic            EN
);

  for (genvar k = 0; k < 2**N; k++) begin : g_out
    assign O[k] = EN & (I == N'(k));
  end

endmodule

// File: rtl/param_pushdown_stack.sv
// DEPTH x WIDTH LIFO with registered top-of-stack, occupancy count and
// sticky overflow/underflow flags.
module param_pushdown_stack
  import param_pushdown_stack_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_TWO  = ADDR_W'(2);
  localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [1:0]        op_s;
  logic              empty_s, full_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_idx_s;
  logic [ADDR_W-1:0] top_idx_s;
  logic [ADDR_W-1:0] below_idx_s;
  logic [DEPTH-1:0]  we_s;
  logic              ovf_set_s, unf_set_s;

  assign empty_s     = (count_q == CNT_ZERO);
  assign full_s      = (count_q == CNT_FULL);
  assign op_s        = decode_op(push, pop, empty_s);
  // Index arithmetic wraps modulo DEPTH; each use is guarded by a count check
  assign top_idx_s   = count_q[ADDR_W-1:0] - IDX_ONE;
  assign below_idx_s = count_q[ADDR_W-1:0] - IDX_TWO;

  // Next-state for count, top-of-stack register, write port and error flags
  always_comb begin
    count_d   = count_q;
    dout_d    = dout_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = count_q[ADDR_W-1:0];
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case (op_s)
      OP_PUSH: begin
        if (!full_s) begin
          wr_en_s = 1'b1;
          count_d = count_q + CNT_ONE;
          dout_d  = din;
        end else begin
          ovf_set_s = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty_s) begin
          count_d = count_q - CNT_ONE;
          if (count_q >= CNT_TWO) begin
            dout_d = mem_q[below_idx_s];
          end else begin
            dout_d = DATA_ZERO;
          end
        end else begin
          unf_set_s = 1'b1;
        end
      end
      OP_REPL: begin
        wr_en_s  = 1'b1;
        wr_idx_s = top_idx_s;
        dout_d   = din;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    overflow_d  = ovf_set_s | (overflow_q  & ~clr_err);
    underflow_d = unf_set_s | (underflow_q & ~clr_err);
  end

  onehot_decoder #(.N(ADDR_W)) u_wr_dec (
    .O  (we_s),
    .I  (wr_idx_s),
    .EN (wr_en_s)
  );

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= CNT_ZERO;
      dout_q      <= DATA_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage; contents are meaningless above count so no reset needed
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (we_s[k]) begin
        mem_q[k] <= din;
      end
    end
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_param_pushdown_stack.sv
// Scoreboard bench: a queue-based stack model predicts each cycle's outputs
// for an 8x8 and a 4x16 instance.
module tb_param_pushdown_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_push, a_pop, a_clr;
  logic [7:0]  a_din, a_dout;
  logic [3:0]  a_count;
  logic        a_empty, a_full, a_ovf, a_unf;
  logic        b_push, b_pop, b_clr;
  logic [15:0] b_din, b_dout;
  logic [2:0]  b_count;
  logic        b_empty, b_full, b_ovf, b_unf;

  param_pushdown_stack #(.WIDTH(8), .DEPTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .push(a_push), .pop(a_pop), .clr_err(a_clr),
    .din(a_din), .dout(a_dout), .count(a_count), .empty(a_empty),
    .full(a_full), .overflow(a_ovf), .underflow(a_unf));

  param_pushdown_stack #(.WIDTH(16), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .push(b_push), .pop(b_pop), .clr_err(b_clr),
    .din(b_din), .dout(b_dout), .count(b_count), .empty(b_empty),
    .full(b_full), .overflow(b_ovf), .underflow(b_unf));

  typedef struct packed {
    logic [15:0] dout;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  logic        m_ovf, m_unf;
  int          sel;
  int          stepn = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = 16'h0000;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  function automatic exp_t model_expect(input int depth);
    exp_t e;
    e.dout  = m_dout;
    e.count = 4'(mq.size());
    e.empty = (mq.size() == 0);
    e.full  = (mq.size() == depth);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic compare_dut(input int which, input string pfx, input exp_t e);
    if (which == 0) begin
      check_val({pfx, ".dout"},  {24'h0, a_dout},  {16'h0, e.dout});
      check_val({pfx, ".count"}, {28'h0, a_count}, {28'h0, e.count});
      check_val({pfx, ".flags"}, {28'h0, a_empty, a_full, a_ovf, a_unf},
                {28'h0, e.empty, e.full, e.ovf, e.unf});
    end else begin
      check_val({pfx, ".dout"},  {16'h0, b_dout},  {16'h0, e.dout});
      check_val({pfx, ".count"}, {29'h0, b_count}, {28'h0, e.count});
      check_val({pfx, ".flags"}, {28'h0, b_empty, b_full, b_ovf, b_unf},
                {28'h0, e.empty, e.full, e.ovf, e.unf});
    end
  endtask

  task automatic step(input logic p, input logic q, input logic c, input logic [15:0] d);
    int          depth;
    logic [15:0] dm;
    logic        so, su;
    exp_t        e;
    depth = (sel != 0) ? 4 : 8;
    dm    = (sel != 0) ? d : {8'h00, d[7:0]};
    so    = 1'b0;
    su    = 1'b0;
    if (sel == 0) begin
      a_push = p; a_pop = q; a_clr = c; a_din = dm[7:0];
    end else begin
      b_push = p; b_pop = q; b_clr = c; b_din = dm;
    end
    if (p && q && mq.size() > 0) begin
      mq[mq.size()-1] = dm;
      m_dout = dm;
    end else if (p) begin
      if (mq.size() < depth) begin
        mq.push_back(dm);
        m_dout = dm;
      end else begin
        so = 1'b1;
      end
    end else if (q) begin
      if (mq.size() > 0) begin
        void'(mq.pop_back());
        m_dout = (mq.size() > 0) ? mq[mq.size()-1] : 16'h0000;
      end else begin
        su = 1'b1;
      end
    end
    m_ovf = so | (m_ovf & ~c);
    m_unf = su | (m_unf & ~c);
    sb.push_back(model_expect(depth));
    @(posedge clk);
    #1;
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0;
    stepn++;
    e = sb.pop_front();
    compare_dut(sel, $sformatf("step%0d", stepn), e);
  endtask

  task automatic async_reset_check(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_dut(0, {tag, ".a"}, model_expect(8));
    compare_dut(1, {tag, ".b"}, model_expect(4));
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_din = 8'h00;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = 16'h0000;
    sel = 0;
    model_reset();
    #2;
    compare_dut(0, "rst.a", model_expect(8));
    compare_dut(1, "rst.b", model_expect(4));
    #1;
    rst_n = 1'b1;

    // 1: idle, 2: push three then drain
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h11);
    step(1'b1, 1'b0, 1'b0, 16'h22);
    step(1'b1, 1'b0, 1'b0, 16'h33);
    check_val("s2.top", {24'h0, a_dout}, 32'h33);
    check_val("s2.count", {28'h0, a_count}, 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    check_val("s2.empty", {31'h0, a_empty}, 32'd1);

    // 4: underflow, clear, set-wins-over-clear
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_val("s4.unf", {31'h0, a_unf}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0);
    check_val("s4.unf_setwins", {31'h0, a_unf}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0);

    // 3: fill, overflow, pop
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 16'(i));
    check_val("s3.full", {31'h0, a_full}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 16'hFF);
    check_val("s3.ovf_dout", {24'h0, a_dout}, 32'h08);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check_val("s3.pop_dout", {24'h0, a_dout}, 32'h07);
    step(1'b1, 1'b0, 1'b1, 16'h08);

    // 5: replace on full, then push&pop on empty
    step(1'b1, 1'b1, 1'b0, 16'hAA);
    check_val("s5.repl_full", {24'h0, a_dout}, 32'hAA);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h5A);
    check_val("s5.repl_empty", {28'h0, a_count}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 16'h0);

    // 6: async reset with five entries held
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'(8'hC0 + i));
    async_reset_check("s6.midrst");
    step(1'b0, 1'b0, 1'b0, 16'h0);

    // 6b: 4x16 instance, scenario 2 plus its own boundaries
    sel = 1;
    step(1'b1, 1'b0, 1'b0, 16'h1111);
    step(1'b1, 1'b0, 1'b0, 16'h2222);
    step(1'b1, 1'b0, 1'b0, 16'h3333);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'(16'hA000 + i));
    step(1'b1, 1'b1, 1'b1, 16'hBEEF);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    check_val("sb.drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
